// File: rtl/spi_rom_line_fetch_if.sv
// SPI bus between the line fetcher (master) and the serial ROM (slave).
interface spi_rom_line_fetch_if;
    logic o_spi_cs_n;
    logic o_spi_sclk;
    logic o_spi_mosi;
    logic spi_miso;

    modport master (
        output o_spi_cs_n,
        output o_spi_sclk,
        output o_spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  o_spi_cs_n,
        input  o_spi_sclk,
        input  o_spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_rom_line_fetch.sv
// Fetches the next scanline's bitmap from an SPI ROM during HBLANK and
// streams it out as 1-bit pixels, each bit held for PIX_W clocks.
module spi_rom_line_fetch #(
    parameter int          DATA_BITS   = 32,
    parameter int          PIX_W       = 20,
    parameter int          FETCH_START = 640,
    parameter int          V_VIEW      = 480,
    parameter logic [23:0] BASE_ADDR   = 24'h0,
    parameter logic [7:0]  READ_CMD    = 8'h03
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [9:0]                  hpos,
    input  logic [9:0]                  vpos,
    input  logic                        hmax,
    input  logic                        vmax,
    input  logic                        visible,
    spi_rom_line_fetch_if.master        spi,
    output logic                        o_pixel,
    output logic                        o_busy,
    output logic                        o_underrun
);

    localparam int PC_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   cs_n_q, cs_n_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;
    logic                   underrun_q, underrun_d;
    logic [31:0]            out_q, out_d;
    logic [DATA_BITS-1:0]   fetch_q, fetch_d;
    logic [DATA_BITS-1:0]   disp_q, disp_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [PC_W-1:0]        pix_cnt_q, pix_cnt_d;

    logic [9:0]             next_line;
    logic                   fetch_en;
    logic                   trigger;
    logic [23:0]            fetch_addr;

    always_comb begin
        next_line  = vmax ? 10'd0 : vpos + 10'd1;
        fetch_en   = next_line < 10'(V_VIEW);
        fetch_addr = BASE_ADDR + 24'(next_line) * 24'(DATA_BITS / 8);
        trigger    = (state_q == ST_IDLE) && (hpos == 10'(FETCH_START)) && fetch_en;
    end

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        underrun_d = 1'b0;
        out_d      = out_q;
        fetch_d    = fetch_q;
        disp_d     = disp_q;
        bit_cnt_d  = bit_cnt_q;
        pix_cnt_d  = pix_cnt_q;

        // End of line wins over everything, including a coincident trigger.
        if (hmax) begin
            pix_cnt_d = '0;
            case (state_q)
                ST_DONE: begin
                    disp_d  = fetch_q;
                    state_d = ST_IDLE;
                end
                ST_IDLE: disp_d = '0;
                default: begin
                    cs_n_d     = 1'b1;
                    sclk_d     = 1'b0;
                    mosi_d     = 1'b0;
                    disp_d     = '0;
                    bit_cnt_d  = '0;
                    underrun_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            endcase
        end else begin
            if (visible) begin
                if (pix_cnt_q == PC_W'(PIX_W - 1)) begin
                    pix_cnt_d = '0;
                    disp_d    = {disp_q[DATA_BITS-2:0], 1'b0};
                end else begin
                    pix_cnt_d = pix_cnt_q + PC_W'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        cs_n_d    = 1'b0;
                        sclk_d    = 1'b0;
                        out_d     = {READ_CMD, fetch_addr};
                        mosi_d    = READ_CMD[7];
                        bit_cnt_d = '0;
                        state_d   = ST_CMD;
                    end
                end
                ST_CMD, ST_ADDR, ST_DATA: begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Once the 32 command/address bits are shifted out, out_q is zero, so mosi idles low in DATA.
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        out_d     = {out_q[30:0], 1'b0};
                        mosi_d    = out_q[30];
                        if (state_q == ST_DATA)
                            fetch_d = {fetch_q[DATA_BITS-2:0], spi.spi_miso};
                        case (state_q)
                            ST_CMD: begin
                                if (bit_cnt_q == 6'd7) begin
                                    bit_cnt_d = '0;
                                    state_d   = ST_ADDR;
                                end
                            end
                            ST_ADDR: begin
                                if (bit_cnt_q == 6'd23) begin
                                    bit_cnt_d = '0;
                                    state_d   = ST_DATA;
                                end
                            end
                            default: begin
                                if (bit_cnt_q == 6'(DATA_BITS - 1)) begin
                                    bit_cnt_d = '0;
                                    cs_n_d    = 1'b1;
                                    state_d   = ST_DONE;
                                end
                            end
                        endcase
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            underrun_q <= 1'b0;
            out_q      <= '0;
            fetch_q    <= '0;
            disp_q     <= '0;
            bit_cnt_q  <= '0;
            pix_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            underrun_q <= underrun_d;
            out_q      <= out_d;
            fetch_q    <= fetch_d;
            disp_q     <= disp_d;
            bit_cnt_q  <= bit_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
        end
    end

    assign spi.o_spi_cs_n = cs_n_q;
    assign spi.o_spi_sclk = sclk_q;
    assign spi.o_spi_mosi = mosi_q;
    assign o_pixel        = visible & disp_q[DATA_BITS-1];
    assign o_busy         = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign o_underrun     = underrun_q;

endmodule
